// File: rtl/axi_sram_slv_pkg.sv
// Shared AXI encodings, widths and FSM states for the SRAM responder.
package axi_sram_slv_pkg;

    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 32;
    localparam int AXI_ID_W   = 4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_DATA,
        WR_DATA,
        WR_RESP
    } state_t;

endpackage

// File: rtl/axi_sram_mem.sv
// Byte-strobed single-port word array: combinational read, synchronous write.
module axi_sram_mem #(
    parameter int DEPTH  = 4096,
    parameter int DATA_W = 32,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic                clk_i,
    input  logic                we,
    input  logic [AW-1:0]       addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] strb,
    output logic [DATA_W-1:0]   rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    always_ff @(posedge clk_i) begin
        if (we) begin
            for (int b = 0; b < DATA_W / 8; b++) begin
                if (strb[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/axi_sram_slv.sv
// AXI4 responder in front of a single-port SRAM; serves one burst at a time
// with alternating AR/AW priority.
module axi_sram_slv
    import axi_sram_slv_pkg::*;
#(
    parameter int                ADDR_W   = AXI_ADDR_W,
    parameter int                DATA_W   = AXI_DATA_W,
    parameter int                ID_W     = AXI_ID_W,
    parameter int                DEPTH    = 4096,
    parameter logic [ADDR_W-1:0] BASE     = ADDR_W'(32'h8000_0000),
    parameter int                READ_LAT = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                slv_aw_valid_i,
    output logic                slv_aw_ready_o,
    input  logic [ADDR_W-1:0]   slv_aw_addr_i,
    input  logic [ID_W-1:0]     slv_aw_id_i,
    input  logic [7:0]          slv_aw_len_i,
    input  logic [2:0]          slv_aw_size_i,
    input  logic [1:0]          slv_aw_burst_i,
    input  logic                slv_w_valid_i,
    output logic                slv_w_ready_o,
    input  logic [DATA_W-1:0]   slv_w_data_i,
    input  logic [DATA_W/8-1:0] slv_w_strb_i,
    input  logic                slv_w_last_i,
    output logic                slv_b_valid_o,
    input  logic                slv_b_ready_i,
    output logic [1:0]          slv_b_resp_o,
    output logic [ID_W-1:0]     slv_b_id_o,
    input  logic                slv_ar_valid_i,
    output logic                slv_ar_ready_o,
    input  logic [ADDR_W-1:0]   slv_ar_addr_i,
    input  logic [ID_W-1:0]     slv_ar_id_i,
    input  logic [7:0]          slv_ar_len_i,
    input  logic [2:0]          slv_ar_size_i,
    input  logic [1:0]          slv_ar_burst_i,
    output logic                slv_r_valid_o,
    input  logic                slv_r_ready_i,
    output logic [DATA_W-1:0]   slv_r_data_o,
    output logic [1:0]          slv_r_resp_o,
    output logic                slv_r_last_o,
    output logic [ID_W-1:0]     slv_r_id_o
);

    localparam int                AW     = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] SPAN   = ADDR_W'(4 * DEPTH);
    localparam logic [7:0]        LAT_M1 = 8'((READ_LAT > 0) ? READ_LAT - 1 : 0);

    state_t              state_q, state_d;
    logic                prio_rd_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [ID_W-1:0]     id_q;
    logic [7:0]          len_q, cnt_q, wait_q;
    logic [2:0]          size_q;
    logic [1:0]          burst_q;
    logic                err_q;

    logic [ADDR_W-1:0]   off, addr_nxt;
    logic                beat_err, last_beat, idle;
    logic                ar_hs, aw_hs, r_hs, w_hs, mem_we;
    logic [DATA_W-1:0]   mem_rdata;

    // Offset wraps for addresses below BASE, so one compare covers both ends.
    assign off       = addr_q - BASE;
    assign beat_err  = (off >= SPAN) || (burst_q >= BURST_WRAP) || (size_q > 3'd2);
    assign last_beat = (cnt_q == len_q);
    assign addr_nxt  = (burst_q == BURST_INCR) ? addr_q + (ADDR_W'(1) << size_q) : addr_q;

    // Readies are held low while reset is asserted, not just after it.
    assign idle           = (state_q == IDLE) && rst_i;
    assign slv_ar_ready_o = idle && (prio_rd_q || !slv_aw_valid_i);
    assign slv_aw_ready_o = idle && (!prio_rd_q || !slv_ar_valid_i);
    assign slv_w_ready_o  = (state_q == WR_DATA);
    assign slv_r_valid_o  = (state_q == RD_DATA);
    assign slv_b_valid_o  = (state_q == WR_RESP);

    assign ar_hs  = slv_ar_valid_i && slv_ar_ready_o;
    assign aw_hs  = slv_aw_valid_i && slv_aw_ready_o;
    assign r_hs   = slv_r_valid_o && slv_r_ready_i;
    assign w_hs   = slv_w_valid_i && slv_w_ready_o;
    assign mem_we = w_hs && !beat_err;

    assign slv_r_data_o = (slv_r_valid_o && !beat_err) ? mem_rdata : '0;
    assign slv_r_resp_o = (slv_r_valid_o && beat_err) ? RESP_SLVERR : RESP_OKAY;
    assign slv_r_last_o = slv_r_valid_o && last_beat;
    assign slv_r_id_o   = slv_r_valid_o ? id_q : '0;
    assign slv_b_resp_o = (slv_b_valid_o && err_q) ? RESP_SLVERR : RESP_OKAY;
    assign slv_b_id_o   = slv_b_valid_o ? id_q : '0;

    axi_sram_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .AW     (AW)
    ) u_mem (
        .clk_i  (clk_i),
        .we     (mem_we),
        .addr   (off[AW+1:2]),
        .wdata  (slv_w_data_i),
        .strb   (slv_w_strb_i),
        .rdata  (mem_rdata)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (ar_hs)      state_d = (READ_LAT == 0) ? RD_DATA : RD_WAIT;
                else if (aw_hs) state_d = WR_DATA;
            end
            RD_WAIT: if (wait_q == LAT_M1) state_d = RD_DATA;
            RD_DATA: if (r_hs && last_beat) state_d = IDLE;
            WR_DATA: if (w_hs && last_beat) state_d = WR_RESP;
            WR_RESP: if (slv_b_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            prio_rd_q <= 1'b1;
            addr_q    <= '0;
            id_q      <= '0;
            len_q     <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            cnt_q     <= '0;
            wait_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            if (ar_hs || aw_hs) begin
                addr_q    <= ar_hs ? slv_ar_addr_i  : slv_aw_addr_i;
                id_q      <= ar_hs ? slv_ar_id_i    : slv_aw_id_i;
                len_q     <= ar_hs ? slv_ar_len_i   : slv_aw_len_i;
                size_q    <= ar_hs ? slv_ar_size_i  : slv_aw_size_i;
                burst_q   <= ar_hs ? slv_ar_burst_i : slv_aw_burst_i;
                cnt_q     <= '0;
                wait_q    <= '0;
                err_q     <= 1'b0;
                prio_rd_q <= !ar_hs;
            end
            if (state_q == RD_WAIT) wait_q <= wait_q + 8'd1;
            if ((r_hs || w_hs) && !last_beat) begin
                cnt_q  <= cnt_q + 8'd1;
                addr_q <= addr_nxt;
            end
            // Beat count governs the burst; a misplaced w_last only flags it.
            if (w_hs && (beat_err || (slv_w_last_i != last_beat))) err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_axi_sram_slv.sv
// Directed bench for axi_sram_slv with a queue/array reference model.
module tb_axi_sram_slv;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        aw_valid, aw_ready;
    logic [31:0] aw_addr;
    logic [3:0]  aw_id;
    logic [7:0]  aw_len;
    logic [2:0]  aw_size;
    logic [1:0]  aw_burst;
    logic        w_valid, w_ready, w_last;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic        b_valid, b_ready;
    logic [1:0]  b_resp;
    logic [3:0]  b_id;
    logic        ar_valid, ar_ready;
    logic [31:0] ar_addr;
    logic [3:0]  ar_id;
    logic [7:0]  ar_len;
    logic [2:0]  ar_size;
    logic [1:0]  ar_burst;
    logic        r_valid, r_ready, r_last;
    logic [31:0] r_data;
    logic [1:0]  r_resp;
    logic [3:0]  r_id;

    always #5 clk = ~clk;

    axi_sram_slv dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .slv_aw_valid_i (aw_valid),
        .slv_aw_ready_o (aw_ready),
        .slv_aw_addr_i  (aw_addr),
        .slv_aw_id_i    (aw_id),
        .slv_aw_len_i   (aw_len),
        .slv_aw_size_i  (aw_size),
        .slv_aw_burst_i (aw_burst),
        .slv_w_valid_i  (w_valid),
        .slv_w_ready_o  (w_ready),
        .slv_w_data_i   (w_data),
        .slv_w_strb_i   (w_strb),
        .slv_w_last_i   (w_last),
        .slv_b_valid_o  (b_valid),
        .slv_b_ready_i  (b_ready),
        .slv_b_resp_o   (b_resp),
        .slv_b_id_o     (b_id),
        .slv_ar_valid_i (ar_valid),
        .slv_ar_ready_o (ar_ready),
        .slv_ar_addr_i  (ar_addr),
        .slv_ar_id_i    (ar_id),
        .slv_ar_len_i   (ar_len),
        .slv_ar_size_i  (ar_size),
        .slv_ar_burst_i (ar_burst),
        .slv_r_valid_o  (r_valid),
        .slv_r_ready_i  (r_ready),
        .slv_r_data_o   (r_data),
        .slv_r_resp_o   (r_resp),
        .slv_r_last_o   (r_last),
        .slv_r_id_o     (r_id)
    );

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [3:0]  id;
    } rbeat_t;

    typedef struct {
        logic [1:0] resp;
        logic [3:0] id;
    } bexp_t;

    int          checks = 0;
    int          passed = 0;
    int          cyc = 0;
    int          rbeats = 0;
    int          wbeats = 0;
    int          bcount = 0;
    int          ar_hs_cyc = 0;
    int          r_first_cyc = 0;
    bit          r_seen = 1'b1;
    bit          log_order = 1'b0;
    string       order = "";
    int          stall_at = -1;
    logic [31:0] mm [int];
    rbeat_t      rq[$];
    bexp_t       bq[$];
    logic [31:0] rlog[$];
    logic        lastlog[$];
    logic [1:0]  last_rresp, last_bresp;
    logic [3:0]  last_rid, last_bid;
    logic [31:0] wbuf [256];

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endfunction

    function automatic void timeout(string name);
        checks++;
        $display("FAIL %s: got no handshake, required one within budget", name);
    endfunction

    function automatic bit beat_bad(logic [31:0] a, logic [2:0] size, logic [1:0] burst);
        bit in_range;
        in_range = (a >= 32'h8000_0000) && (a < 32'h8000_4000);
        return !in_range || (burst >= 2'd2) || (size > 3'd2);
    endfunction

    function automatic void model_read(logic [31:0] addr, logic [3:0] id,
                                       logic [7:0] len, logic [2:0] size,
                                       logic [1:0] burst);
        logic [31:0] a;
        rbeat_t      e;
        a = addr;
        for (int i = 0; i <= int'(len); i++) begin
            e.resp = beat_bad(a, size, burst) ? 2'b10 : 2'b00;
            e.data = (e.resp != 2'b00) ? 32'h0 : mm[int'(a[31:2])];
            e.last = (i == int'(len));
            e.id   = id;
            rq.push_back(e);
            if (burst == 2'd1) a = a + (32'd1 << size);
        end
    endfunction

    function automatic void model_write(logic [31:0] addr, logic [3:0] id,
                                        logic [7:0] len, logic [2:0] size,
                                        logic [1:0] burst, logic [3:0] strb,
                                        int bad_last);
        logic [31:0] a, w;
        bit          err, lst;
        bexp_t       e;
        a   = addr;
        err = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            lst = (bad_last >= 0) ? (i == bad_last) : (i == int'(len));
            if (lst != (i == int'(len))) err = 1'b1;
            if (beat_bad(a, size, burst)) begin
                err = 1'b1;
            end else begin
                w = mm.exists(int'(a[31:2])) ? mm[int'(a[31:2])] : 32'h0;
                for (int b = 0; b < 4; b++)
                    if (strb[b]) w[b*8 +: 8] = wbuf[i][b*8 +: 8];
                mm[int'(a[31:2])] = w;
            end
            if (burst == 2'd1) a = a + (32'd1 << size);
        end
        e.resp = err ? 2'b10 : 2'b00;
        e.id   = id;
        bq.push_back(e);
    endfunction

    always @(negedge clk) begin
        rbeat_t re;
        bexp_t  be;
        cyc++;
        if (rst) begin
            if (ar_valid && ar_ready) begin
                ar_hs_cyc = cyc;
                r_seen    = 1'b0;
                if (log_order) order = {order, "R"};
            end
            if (aw_valid && aw_ready && log_order) order = {order, "W"};
            if (r_valid && !r_seen) begin
                r_first_cyc = cyc;
                r_seen      = 1'b1;
            end
            if (ar_valid && aw_valid) chk("ready_exclusive", 64'(ar_ready && aw_ready), 64'd0);
            if (w_valid && w_ready) wbeats++;
            if (r_valid && !r_ready && rq.size() > 0) begin
                chk("r_stall_data", r_data, rq[0].data);
                chk("r_stall_last", r_last, rq[0].last);
            end
            if (r_valid && r_ready) begin
                rbeats++;
                rlog.push_back(r_data);
                lastlog.push_back(r_last);
                last_rresp = r_resp;
                last_rid   = r_id;
                if (rq.size() == 0) begin
                    chk("r_unexpected_beat", 64'd1, 64'd0);
                end else begin
                    re = rq.pop_front();
                    chk("r_data", r_data, re.data);
                    chk("r_resp", r_resp, re.resp);
                    chk("r_last", r_last, re.last);
                    chk("r_id", r_id, re.id);
                end
            end
            if (b_valid && b_ready) begin
                bcount++;
                last_bresp = b_resp;
                last_bid   = b_id;
                if (bq.size() == 0) begin
                    chk("b_unexpected", 64'd1, 64'd0);
                end else begin
                    be = bq.pop_front();
                    chk("b_resp", b_resp, be.resp);
                    chk("b_id", b_id, be.id);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_ar(logic [31:0] addr, logic [3:0] id, logic [7:0] len,
                           logic [2:0] size, logic [1:0] burst, bit wait_done);
        int n;
        int base;
        tick();
        model_read(addr, id, len, size, burst);
        base     = rbeats;
        ar_valid = 1'b1;
        ar_addr  = addr;
        ar_id    = id;
        ar_len   = len;
        ar_size  = size;
        ar_burst = burst;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ar_ready && n < 500);
        if (!ar_ready) timeout("ar_handshake");
        tick();
        ar_valid = 1'b0;
        if (stall_at >= 0) begin
            n = 0;
            while (rbeats < base + stall_at && n < 500) begin
                @(posedge clk);
                n++;
            end
            #1 r_ready = 1'b0;
            repeat (5) tick();
            r_ready = 1'b1;
        end
        if (wait_done) begin
            n = 0;
            while (rq.size() != 0 && n < 2000) begin
                @(posedge clk);
                n++;
            end
            if (rq.size() != 0) timeout("r_burst_done");
        end
    endtask

    task automatic send_wr(logic [31:0] addr, logic [3:0] id, logic [7:0] len,
                           logic [2:0] size, logic [1:0] burst, logic [3:0] strb,
                           int bad_last);
        int n;
        tick();
        model_write(addr, id, len, size, burst, strb, bad_last);
        aw_valid = 1'b1;
        aw_addr  = addr;
        aw_id    = id;
        aw_len   = len;
        aw_size  = size;
        aw_burst = burst;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!aw_ready && n < 500);
        if (!aw_ready) timeout("aw_handshake");
        tick();
        aw_valid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            w_valid = 1'b1;
            w_data  = wbuf[i];
            w_strb  = strb;
            w_last  = (bad_last >= 0) ? (i == bad_last) : (i == int'(len));
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!w_ready && n < 500);
            if (!w_ready) timeout("w_handshake");
            tick();
        end
        w_valid = 1'b0;
        w_last  = 1'b0;
        n = 0;
        while (bq.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        if (bq.size() != 0) timeout("b_response");
    endtask

    initial begin
        int base;
        int n;
        aw_valid = 0; aw_addr = 0; aw_id = 0; aw_len = 0; aw_size = 0; aw_burst = 0;
        w_valid = 0; w_data = 0; w_strb = 0; w_last = 0; b_ready = 1;
        ar_valid = 0; ar_addr = 0; ar_id = 0; ar_len = 0; ar_size = 0; ar_burst = 0;
        r_ready = 1;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ar_ready", ar_ready, 0);
        chk("rst_aw_ready", aw_ready, 0);
        chk("rst_w_ready", w_ready, 0);
        chk("rst_r_valid", r_valid, 0);
        chk("rst_b_valid", b_valid, 0);
        chk("rst_r_data", r_data, 0);
        chk("rst_r_last", r_last, 0);
        chk("rst_r_id", r_id, 0);
        chk("rst_b_resp", b_resp, 0);
        #2 rst = 1'b1;
        @(negedge clk);
        chk("idle_ar_ready", ar_ready, 1);
        chk("idle_aw_ready", aw_ready, 1);

        // Single read with latency check
        wbuf[0] = 32'hDEAD_BEEF;
        send_wr(32'h8000_0010, 4'd1, 8'd0, 3'd2, 2'd1, 4'hF, -1);
        chk("wr1_bresp", last_bresp, 2'b00);
        rlog.delete();
        send_ar(32'h8000_0010, 4'd3, 8'd0, 3'd2, 2'd1, 1'b1);
        chk("rd1_latency", 64'(r_first_cyc - ar_hs_cyc), 64'd2);
        chk("rd1_data", rlog[0], 32'hDEAD_BEEF);
        chk("rd1_resp", last_rresp, 2'b00);
        chk("rd1_last", lastlog[0], 1'b1);
        chk("rd1_id", last_rid, 4'd3);

        // INCR write then read-back
        for (int i = 0; i < 4; i++) wbuf[i] = 32'(i + 1);
        base = bcount;
        send_wr(32'h8000_0000, 4'd2, 8'd3, 3'd2, 2'd1, 4'hF, -1);
        chk("incr_b_count", 64'(bcount - base), 64'd1);
        chk("incr_bresp", last_bresp, 2'b00);
        rlog.delete();
        lastlog.delete();
        send_ar(32'h8000_0000, 4'd4, 8'd3, 3'd2, 2'd1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk("incr_rd_data", rlog[i], 32'(i + 1));
            chk("incr_rd_last", lastlog[i], (i == 3));
        end

        // Backpressure mid-burst
        for (int i = 0; i < 8; i++) wbuf[i] = 32'h100 + 32'(i);
        send_wr(32'h8000_0200, 4'd5, 8'd7, 3'd2, 2'd1, 4'hF, -1);
        stall_at = 3;
        send_ar(32'h8000_0200, 4'd6, 8'd7, 3'd2, 2'd1, 1'b1);
        stall_at = -1;

        // Byte strobes
        wbuf[0] = 32'h1111_1111;
        send_wr(32'h8000_0020, 4'd7, 8'd0, 3'd2, 2'd1, 4'hF, -1);
        wbuf[0] = 32'hAABB_CCDD;
        send_wr(32'h8000_0020, 4'd7, 8'd0, 3'd2, 2'd1, 4'h3, -1);
        rlog.delete();
        send_ar(32'h8000_0020, 4'd8, 8'd0, 3'd2, 2'd1, 1'b1);
        chk("strb_merge", rlog[0], 32'h1111_CCDD);

        // Out-of-range read
        rlog.delete();
        send_ar(32'h7FFF_FFFC, 4'd9, 8'd0, 3'd2, 2'd1, 1'b1);
        chk("oor_rresp", last_rresp, 2'b10);
        chk("oor_rdata", rlog[0], 32'h0);

        // WRAP write is rejected and leaves memory alone
        wbuf[0] = 32'h5555_AAAA;
        wbuf[1] = 32'h6666_BBBB;
        send_wr(32'h8000_0040, 4'd10, 8'd1, 3'd2, 2'd1, 4'hF, -1);
        wbuf[0] = 32'hFFFF_FFFF;
        wbuf[1] = 32'hEEEE_EEEE;
        send_wr(32'h8000_0040, 4'd11, 8'd1, 3'd2, 2'd2, 4'hF, -1);
        chk("wrap_bresp", last_bresp, 2'b10);
        rlog.delete();
        send_ar(32'h8000_0040, 4'd12, 8'd1, 3'd2, 2'd1, 1'b1);
        chk("wrap_mem0", rlog[0], 32'h5555_AAAA);
        chk("wrap_mem1", rlog[1], 32'h6666_BBBB);

        // Early w_last
        for (int i = 0; i < 4; i++) wbuf[i] = 32'hA0 + 32'(i);
        base = wbeats;
        send_wr(32'h8000_0060, 4'd13, 8'd3, 3'd2, 2'd1, 4'hF, 1);
        chk("early_last_beats", 64'(wbeats - base), 64'd4);
        chk("early_last_bresp", last_bresp, 2'b10);
        chk("early_last_bid", last_bid, 4'd13);

        // FIXED burst keeps hitting one word
        wbuf[0] = 32'h0A; wbuf[1] = 32'h0B; wbuf[2] = 32'h0C;
        send_wr(32'h8000_0070, 4'd1, 8'd2, 3'd2, 2'd0, 4'hF, -1);
        rlog.delete();
        send_ar(32'h8000_0070, 4'd2, 8'd1, 3'd2, 2'd0, 1'b1);
        chk("fixed_rd0", rlog[0], 32'h0C);

        // 256-beat burst
        for (int i = 0; i < 256; i++) wbuf[i] = 32'(i * 3 + 7);
        send_wr(32'h8000_0400, 4'd3, 8'd255, 3'd2, 2'd1, 4'hF, -1);
        rlog.delete();
        send_ar(32'h8000_0400, 4'd4, 8'd255, 3'd2, 2'd1, 1'b1);
        chk("len255_beats", 64'(rlog.size()), 64'd256);
        chk("len255_final", rlog[255], 32'h304);

        // Arbitration from reset: R, W, R, W
        tick();
        rst = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        wbuf[0] = 32'hCAFE_0001;
        order = "";
        log_order = 1'b1;
        fork
            begin
                send_ar(32'h8000_0000, 4'd1, 8'd1, 3'd2, 2'd1, 1'b1);
                send_ar(32'h8000_0200, 4'd2, 8'd1, 3'd2, 2'd1, 1'b1);
            end
            begin
                send_wr(32'h8000_0080, 4'd3, 8'd0, 3'd2, 2'd1, 4'hF, -1);
                send_wr(32'h8000_0084, 4'd4, 8'd0, 3'd2, 2'd1, 4'hF, -1);
            end
        join
        log_order = 1'b0;
        checks++;
        if (order == "RWRW") passed++;
        else $display("FAIL arb_order: got %s, required RWRW", order);

        // Reset in the middle of an 8-beat read
        base = rbeats;
        send_ar(32'h8000_0200, 4'd5, 8'd7, 3'd2, 2'd1, 1'b0);
        n = 0;
        while (rbeats < base + 2 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (rbeats < base + 2) timeout("midburst_beats");
        #3 rst = 1'b0;
        rq.delete();
        #1;
        chk("midrst_r_valid", r_valid, 0);
        chk("midrst_ar_ready", ar_ready, 0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        chk("postrst_ar_ready", ar_ready, 1);
        chk("postrst_r_valid", r_valid, 0);
        rlog.delete();
        send_ar(32'h8000_0200, 4'd6, 8'd7, 3'd2, 2'd1, 1'b1);
        chk("retained_word7", rlog[7], 32'h107);

        repeat (3) tick();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/axi_sram_slv.md
Name: axi_sram_slv

Overview:
- AXI4 responder (slave) with an internal word-addressed memory array.
- It is the far end of the core's AXI master port: it serves IFU instruction fetches and LSU loads/stores.
- It replaces the hard-wired arready/rvalid/rdata stubs in the top level.
- Single-port array: one transaction (read burst or write burst) is in service at a time; AR/AW arbitration alternates.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; strobe width is DATA_W/8
- ID_W, 4, transaction ID width
- DEPTH, 4096, number of DATA_W words in the array
- BASE, 32'h8000_0000, byte address of word 0
- READ_LAT, 1, idle cycles between AR accept and first rvalid (0 allowed)

Ports:
- clk_i in 1 clock
- rst_i in 1 reset; asynchronous, active-low
- slv_aw_valid_i in 1; slv_aw_ready_o out 1; slv_aw_addr_i in ADDR_W; slv_aw_id_i in ID_W; slv_aw_len_i in 8; slv_aw_size_i in 3; slv_aw_burst_i in 2
- slv_w_valid_i in 1; slv_w_ready_o out 1; slv_w_data_i in DATA_W; slv_w_strb_i in DATA_W/8; slv_w_last_i in 1
- slv_b_valid_o out 1; slv_b_ready_i in 1; slv_b_resp_o out 2; slv_b_id_o out ID_W
- slv_ar_valid_i in 1; slv_ar_ready_o out 1; slv_ar_addr_i in ADDR_W; slv_ar_id_i in ID_W; slv_ar_len_i in 8; slv_ar_size_i in 3; slv_ar_burst_i in 2
- slv_r_valid_o out 1; slv_r_ready_i in 1; slv_r_data_o out DATA_W; slv_r_resp_o out 2; slv_r_last_o out 1; slv_r_id_o out ID_W

Behaviour:
- Reset (rst_i=0, async) forces:
  - state IDLE;
  - all valid/ready outputs 0; r_data, r_resp, b_resp, ids and r_last 0;
  - priority flag to "read first".
  - The memory array is NOT reset. Reset mid-burst abandons the burst; no further beats or responses are produced.
- FSM states: IDLE, RD_WAIT, RD_DATA, WR_DATA, WR_RESP.
- IDLE readiness:
  - Read priority: ar_ready=1 and aw_ready=!ar_valid_i.
  - Write priority: aw_ready=1 and ar_ready=!aw_valid_i.
  - ar_ready and aw_ready are never both high while both valids are asserted. Both readies are 0 outside IDLE.
- Priority flag: after each accepted address, priority passes to the other channel. Simultaneous valids therefore alternate R, W, R, ...
- On AR handshake:
  - Latch addr, id, len, size, burst; clear the beat counter.
  - Go to RD_WAIT for READ_LAT cycles, then RD_DATA. READ_LAT=0 goes straight to RD_DATA.
- RD_DATA:
  - r_valid=1; r_data = array[(addr-BASE)>>2]; r_id = latched id.
  - r_last=1 when beat counter == len.
  - Outputs hold stable while r_valid && !r_ready.
  - On each handshake: counter+1; INCR advances addr by (1<<size); FIXED holds addr.
  - Handshake on the last beat returns to IDLE. Throughput is one beat per cycle.
- On AW handshake: latch fields, clear the beat counter and error flag, go to WR_DATA with w_ready=1.
- WR_DATA:
  - Each w handshake writes the bytes enabled by w_strb into the addressed word; addr advances as for reads.
  - Beat len is the final beat, and the block goes to WR_RESP.
  - If w_last disagrees with (counter==len) on any beat, the error flag is set (sticky) and the beat count still governs.
- WR_RESP: b_valid=1, b_id = latched id, b_resp = 2'b10 if the error flag is set, else 2'b00. On b_ready go to IDLE.
- Error handling:
  - Address outside [BASE, BASE+4*DEPTH), or burst==WRAP(2'b10) or reserved(2'b11), gives SLVERR (2'b10) on that beat/response.
  - Erroring reads return data 0; erroring writes are suppressed.
  - Burst length is still honoured on error.
- Narrow size (<2): addressing uses full words; the master's strobes select bytes. Size >2 is treated as SLVERR.
- The beat counter is 8 bits; len=255 gives 256 beats with no wrap before the last beat.

Decomposition:
- Shared package/defines holds:
  - AXI resp constants (OKAY=2'b00, SLVERR=2'b10);
  - burst encodings (FIXED=0, INCR=1, WRAP=2);
  - the FSM state enum;
  - the AXI widths (axi_addr, axi_data, id).
- One sub-module: axi_sram_mem, a byte-strobed single-port array with combinational read and synchronous write.

Test Plan:
- Single read: ar addr=0x8000_0010, len=0, id=3, READ_LAT=1, array[4]=0xDEAD_BEEF -> r_valid 2 cycles after AR handshake; data 0xDEADBEEF, resp 0, last=1, id=3.
- INCR write then read: aw addr=0x8000_0000, len=3, data 1,2,3,4, strb 0xF -> b_resp=0 once; read-back len=3 returns 1,2,3,4 with last only on beat 4.
- Backpressure and strobes:
  - r_ready held low 5 cycles mid-burst -> r_data/r_last stable.
  - Write strb=0x3 of 0xAABB_CCDD onto 0x1111_1111 -> reads 0x1111_CCDD.
- Arbitration: ar_valid and aw_valid asserted together from reset, each repeated -> service order R, W, R, W.
- Errors:
  - Read at 0x7FFF_FFFC -> r_resp=2'b10, data 0.
  - WRAP write -> b_resp=2'b10 and memory unchanged.
  - Early w_last at beat 1 of len=3 -> b_resp=2'b10 after 4 beats.
- Reset mid-burst: assert rst_i during beat 2 of an 8-beat read -> r_valid drops immediately; after release, IDLE with ar_ready=1; memory contents retained.
